// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: default width and the fixed opcode map.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_NOT  = 4'b0101,
    OP_INC  = 4'b0110,
    OP_DEC  = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1001,
    OP_ROL  = 4'b1010,
    OP_CMP  = 4'b1011,
    OP_ROR  = 4'b1100,
    OP_CLR  = 4'b1101,
    OP_MOVA = 4'b1110,
    OP_MOVB = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, op -> next result and Z/C/N flags.
// Defining ALU_SAT_EN makes ADD/SUB saturate unsigned instead of wrapping.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] res,
  output logic             z,
  output logic             c,
  output logic             n
);

  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic [WIDTH:0] inc;
  logic [WIDTH:0] dec;
  logic           cmp_mode;

  // Top bit of each extended result is the carry (add) or borrow (subtract).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign inc  = {1'b0, a} + ONE;
  assign dec  = {1'b0, a} - ONE;

  always_comb begin
    res      = '0;
    c        = 1'b0;
    cmp_mode = 1'b0;
    case (op)
      OP_ADD: begin
`ifdef ALU_SAT_EN
        res = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        res = sum[WIDTH-1:0];
`endif
        c   = sum[WIDTH];
      end
      OP_SUB: begin
`ifdef ALU_SAT_EN
        res = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        res = diff[WIDTH-1:0];
`endif
        c   = diff[WIDTH];
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_INC: begin
        res = inc[WIDTH-1:0];
        c   = inc[WIDTH];
      end
      OP_DEC: begin
        res = dec[WIDTH-1:0];
        c   = dec[WIDTH];
      end
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_ROL: begin
        res = {a[WIDTH-2:0], a[WIDTH-1]};
        c   = a[WIDTH-1];
      end
      OP_CMP: begin
        res      = diff[WIDTH-1:0];
        cmp_mode = 1'b1;
      end
      OP_ROR: begin
        res = {a[0], a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_CLR:  res = '0;
      OP_MOVA: res = a;
      OP_MOVB: res = b;
      default: res = '0;
    endcase

    // CMP reports a one-hot relation instead of describing the difference.
    if (cmp_mode) begin
      z = (a == b);
      n = diff[WIDTH];
      c = (a != b) && !diff[WIDTH];
    end else begin
      z = (res == '0);
      n = res[WIDTH-1];
    end
  end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU top: alu_core datapath feeding an enable-gated, async-reset
// result/flag register. Optional unsigned saturation via ALU_SAT_EN (in alu_core).
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] out,
  output logic             z_flag,
  output logic             c_flag,
  output logic             n_flag
);

  logic [WIDTH-1:0] res_next;
  logic             z_next;
  logic             c_next;
  logic             n_next;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a   (a),
    .b   (b),
    .op  (op),
    .res (res_next),
    .z   (z_next),
    .c   (c_next),
    .n   (n_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out    <= '0;
      z_flag <= 1'b0;
      c_flag <= 1'b0;
      n_flag <= 1'b0;
    end else if (en) begin
      out    <= res_next;
      z_flag <= z_next;
      c_flag <= c_next;
      n_flag <= n_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: table of directed vectors, hand-written reset/enable sequences,
// and random vectors checked against a behavioural model through an expected queue.
module tb_alu;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic [W-1:0] out;
  logic         z_flag;
  logic         c_flag;
  logic         n_flag;

  alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .a      (a),
    .b      (b),
    .op     (op),
    .out    (out),
    .z_flag (z_flag),
    .c_flag (c_flag),
    .n_flag (n_flag)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected record packed as {out, z, c, n}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] held;
  int total;
  int bad;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] eo;
    logic         ez;
    logic         ec;
    logic         en_flag;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic [3:0] mop);
    int sa;
    int sb;
    int t;
    logic [W-1:0] r;
    logic mz;
    logic mc;
    logic mn;
    sa = int'(ma);
    sb = int'(mb);
    r  = '0;
    mc = 1'b0;
    case (mop)
      OP_ADD: begin
        t  = sa + sb;
        mc = (t > 255);
        r  = W'(t);
`ifdef ALU_SAT_EN
        if (mc) r = 8'hFF;
`endif
      end
      OP_SUB: begin
        mc = (sa < sb);
        r  = W'(sa - sb);
`ifdef ALU_SAT_EN
        if (mc) r = 8'h00;
`endif
      end
      OP_AND:  r = ma & mb;
      OP_OR:   r = ma | mb;
      OP_XOR:  r = ma ^ mb;
      OP_NOT:  r = ~ma;
      OP_INC: begin r = W'(sa + 1); mc = (sa == 255); end
      OP_DEC: begin r = W'(sa - 1); mc = (sa == 0); end
      OP_SHL: begin r = W'(sa * 2); mc = ma[W-1]; end
      OP_SHR: begin r = W'(sa / 2); mc = ma[0]; end
      OP_ROL: begin r = W'((sa * 2) % 256 + sa / 128); mc = ma[W-1]; end
      OP_ROR: begin r = W'((sa % 2) * 128 + sa / 2); mc = ma[0]; end
      OP_CMP:  r = W'(sa - sb);
      OP_CLR:  r = '0;
      OP_MOVA: r = ma;
      OP_MOVB: r = mb;
      default: r = '0;
    endcase
    mz = (r == 0);
    mn = (r >= 8'h80);
    if (mop == OP_CMP) begin
      mz = (sa == sb);
      mn = (sa < sb);
      mc = (sa > sb);
    end
    return {r, mz, mc, mn};
  endfunction

  // scoreboard
  task automatic check(input string name);
    logic [W+2:0] exp;
    logic [W+2:0] act;
    act = {out, z_flag, c_flag, n_flag};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expected entry, got out=%02h z=%0b c=%0b n=%0b",
               name, act[W+2:3], act[2], act[1], act[0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        bad++;
        $display("FAIL %s: got out=%02h z=%0b c=%0b n=%0b, want out=%02h z=%0b c=%0b n=%0b",
                 name, act[W+2:3], act[2], act[1], act[0],
                 exp[W+2:3], exp[2], exp[1], exp[0]);
      end
    end
  endtask

  // driver: apply at negedge, expect result just after the next rising edge
  task automatic drive(input logic e, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [3:0] iop, input logic [W+2:0] exp, input string name);
    @(negedge clk);
    en = e;
    a  = ia;
    b  = ib;
    op = iop;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    a     = '0;
    b     = '0;
    op    = '0;
    held  = '0;

    vecs[0]  = '{8'd10,  8'd5,   OP_ADD,  8'd15,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'd10,  8'd5,   OP_SUB,  8'd5,   1'b0, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
    vecs[2]  = '{8'd200, 8'd100, OP_ADD,  8'd255, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{8'd5,   8'd10,  OP_SUB,  8'h00,  1'b1, 1'b1, 1'b0};
    vecs[20] = '{8'hFF,  8'h01,  OP_ADD,  8'hFF,  1'b0, 1'b1, 1'b1};
`else
    vecs[2]  = '{8'd200, 8'd100, OP_ADD,  8'd44,  1'b0, 1'b1, 1'b0};
    vecs[12] = '{8'd5,   8'd10,  OP_SUB,  8'hFB,  1'b0, 1'b1, 1'b1};
    vecs[20] = '{8'hFF,  8'h01,  OP_ADD,  8'h00,  1'b1, 1'b1, 1'b0};
`endif
    vecs[3]  = '{8'h81,  8'h00,  OP_ROL,  8'h03,  1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h81,  8'h00,  OP_ROR,  8'hC0,  1'b0, 1'b1, 1'b1};
    vecs[5]  = '{8'd20,  8'd50,  OP_CMP,  8'hE2,  1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'd100, 8'd30,  OP_CMP,  8'd70,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'd77,  8'd77,  OP_CMP,  8'd0,   1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF,  8'h3C,  OP_INC,  8'h00,  1'b1, 1'b1, 1'b0};
    vecs[9]  = '{8'h00,  8'h3C,  OP_DEC,  8'hFF,  1'b0, 1'b1, 1'b1};
    vecs[10] = '{8'h01,  8'h00,  OP_SHR,  8'h00,  1'b1, 1'b1, 1'b0};
    vecs[11] = '{8'h5A,  8'h33,  OP_CLR,  8'h00,  1'b1, 1'b0, 1'b0};
    vecs[13] = '{8'hF0,  8'h3C,  OP_AND,  8'h30,  1'b0, 1'b0, 1'b0};
    vecs[14] = '{8'hF0,  8'h0F,  OP_OR,   8'hFF,  1'b0, 1'b0, 1'b1};
    vecs[15] = '{8'hAA,  8'hAA,  OP_XOR,  8'h00,  1'b1, 1'b0, 1'b0};
    vecs[16] = '{8'h0F,  8'h00,  OP_NOT,  8'hF0,  1'b0, 1'b0, 1'b1};
    vecs[17] = '{8'h81,  8'h00,  OP_SHL,  8'h02,  1'b0, 1'b1, 1'b0};
    vecs[18] = '{8'h80,  8'h11,  OP_MOVA, 8'h80,  1'b0, 1'b0, 1'b1};
    vecs[19] = '{8'h80,  8'h00,  OP_MOVB, 8'h00,  1'b1, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 8'd10, 8'd5, OP_ADD, held, "reset_state");

    foreach (vecs[i]) begin
      held = {vecs[i].eo, vecs[i].ez, vecs[i].ec, vecs[i].en_flag};
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, held, $sformatf("vec%0d", i));
    end

    // CLR then hold with enable low, then release
    held = {8'h00, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 8'h77, 8'h66, OP_CLR, held, "clr");
    for (int k = 0; k < 3; k++)
      drive(1'b0, 8'd10, 8'd5, OP_ADD, held, $sformatf("hold%0d", k));
    held = {8'd15, 1'b0, 1'b0, 1'b0};
    drive(1'b1, 8'd10, 8'd5, OP_ADD, held, "en_release");

    // async reset mid-cycle with a nonzero result registered
    #2;
    rst_n = 1'b0;
    #1;
    held = '0;
    exp_q.push_back(held);
    check("async_rst");
    drive(1'b1, 8'd10, 8'd5, OP_ADD, held, "rst_discard");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 40; k++) begin
      logic         re;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [3:0]   rop;
      re  = ($urandom_range(0, 3) != 0);
      ra  = W'($urandom_range(0, 255));
      rb  = W'($urandom_range(0, 255));
      rop = 4'($urandom_range(0, 15));
      if (re) held = model(ra, rb, rop);
      drive(re, ra, rb, rop, held, $sformatf("rand%0d", k));
    end

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover: %0d expected entries not consumed, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
